array_drain: RTL and testbench
==============================

# array_drain

Result-collection stage directly downstream of the 64-lane SIMD MAC array. Counts a programmed number of accumulation cycles, snapshots all 64 accumulator outputs in one edge, then serializes the snapshot as 8 beats of 8 lanes over a valid/ready stream toward the writeback path. This frees the array's outputs immediately after capture while the narrow result bus drains.

## Interface
- `LANES`, 64: number of array lanes. Must be a multiple of `BEAT_LANES`.
- `BEAT_LANES`, 8: lanes per output beat. `NBEATS = LANES/BEAT_LANES` (8).
- `LEN_W`, 16: width of the accumulation-length field.
- Lane width is `2*MAC_BW`, where `MAC_BW` is the macro from `param_def.sv`.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `iC`, in, `[2*MAC_BW-1:0] [LANES-1:0]`: accumulator outputs from the array.
- `iStart`, in, 1: single-cycle request to begin a count/capture/drain sequence.
- `iLen`, in, `LEN_W`: accumulation cycles to wait. Sampled only when a start is accepted.
- `oData`, out, `[2*MAC_BW-1:0] [BEAT_LANES-1:0]`: current beat.
- `oValid`, out, 1: `oData` is valid.
- `iReady`, in, 1: the consumer accepts the beat.
- `oLast`, out, 1: the current beat is the final beat (`NBEATS-1`).
- `oBusy`, out, 1: the block is not in IDLE.
- `oDrop`, out, 1: one-cycle pulse when an `iStart` is ignored.

## Operation
- FSM states are IDLE, COUNT and DRAIN.
- **IDLE**
  - On `iStart` with `iLen>0`: load `cnt = iLen-1` and go to COUNT.
  - On `iStart` with `iLen==0`: capture `iC` into the snapshot on that same edge and go to DRAIN.
- **COUNT**
  - When `cnt==0`: capture `iC` into the snapshot and go to DRAIN, with `beat=0`.
  - Otherwise decrement `cnt`.
- **DRAIN**
  - `oValid=1`.
  - `oData = snapshot lanes [beat*BEAT_LANES +: BEAT_LANES]`, with lane 0 in the lowest element.
  - `oLast = (beat==NBEATS-1)`.
  - On `oValid && iReady`: if not last, `beat++`; if last, go to IDLE.
- `iStart` is accepted only in IDLE.
  - In COUNT or DRAIN, including the cycle of the final handshake, `iStart` is ignored and `oDrop` pulses the next cycle.
- No arithmetic is done on the data. Lanes pass through bit-exact at width `2*MAC_BW`.
- `oData` is forced to 0 whenever `oValid==0`.
- `oBusy = (state != IDLE)`.

## Timing
- **Reset values:** state IDLE, `cnt=0`, `beat=0`, snapshot all 0, `oValid=0`, `oLast=0`, `oData=0`, `oBusy=0`, `oDrop=0`.
- **Reset mid-operation:** the block aborts to IDLE immediately (asynchronously) and emits no partial beats after release.
- **Capture latency:** a start accepted at edge t0 captures `iC` at edge t0+`iLen` (t0 itself when `iLen==0`). `oValid` rises after that capture edge.
- **Beat timing:** with `iReady` held high, one beat per cycle, so 8 beats occupy 8 consecutive cycles. The earliest next start is accepted the cycle after the final handshake.
- **Handshake rules:**
  - While `oValid=1 && iReady=0`, `oData`, `oLast` and `beat` hold stable.
  - `oValid` never drops before its handshake.
  - `iReady` may toggle arbitrarily. The block does not depend on `iReady` when `oValid=0`.
- **Snapshot stability:** the snapshot is written only at the capture edge. Later changes on `iC` do not affect the beats being drained.
- `oData` and `oLast` are driven from registered state (the snapshot and `beat`) through the lane mux. There is no combinational path from `iC` or `iReady` to any output.
- **`iLen` limits:** maximum `iLen = 2^LEN_W - 1`. The counter does not wrap.

## Structure
- Shared package `array_pkg` holds:
  - `LANES` and `BEAT_LANES`;
  - the `lane_t` typedef (`logic [2*MAC_BW-1:0]`);
  - the state enum `drain_state_e` (IDLE, COUNT, DRAIN).
- Single module. No sub-module is warranted: the FSM, counters and beat mux are small and tightly coupled.

## Test plan
All scenarios use `MAC_BW=8` (16-bit lanes) with `iC[i] = 16'h0100*k + i`, where k is the cycle number since reset.
- **Basic drain:** start with `iLen=3` at edge k=10, `iReady` held high.
  - Capture at k=13.
  - 8 consecutive beats; beat b lane j = `0x0D00 + 8b + j`.
  - `oLast` on beat 7 only; `oBusy` falls the cycle after.
- **Zero length:** start with `iLen=0` at k=20.
  - Snapshot taken at k=20.
  - First beat lanes = `0x1400..0x1407`.
- **Backpressure:** `iReady` follows the pattern 1,0,0,1 repeating.
  - `oData` is stable across every stall.
  - Exactly 8 handshakes, order preserved.
  - Values are unaffected by `iC` changing during the drain.
- **Dropped start:** `iStart` pulsed during COUNT, mid-DRAIN, and on the final-handshake cycle.
  - Each produces an `oDrop` pulse.
  - No second sequence runs.
  - A start the next cycle after the final handshake is accepted.
- **Reset mid-DRAIN:** assert `rst_n=0` after beat 3.
  - All outputs are 0 asynchronously.
  - After release: IDLE, `oValid=0` until a new start.
- **Long length:** `iLen=16'hFFFF`.
  - Capture occurs exactly 65535 cycles after acceptance.
  - No early `oValid`.

Source files
------------

// File: rtl/array_pkg.sv
// Shared types and sizing for the MAC array and its result-drain stage.
`ifndef MAC_BW
`define MAC_BW 8
`endif

package array_pkg;

    localparam int unsigned LANES      = 64;
    localparam int unsigned BEAT_LANES = 8;
    localparam int unsigned LANE_W     = 2 * `MAC_BW;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DRAIN
    } drain_state_e;

endpackage

// File: rtl/param_def.sv
// Global build parameters shared by the array datapath.
`ifndef MAC_BW
`define MAC_BW 8
`endif

// File: rtl/array_drain.sv
// Result-collection stage: waits a programmed number of accumulation cycles,
// snapshots every accumulator lane in one edge, then streams the snapshot
// out as NBEATS beats of BEAT_LANES lanes over a valid/ready interface.
module array_drain #(
    parameter int unsigned LANES      = array_pkg::LANES,
    parameter int unsigned BEAT_LANES = array_pkg::BEAT_LANES,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [LANES-1:0][array_pkg::LANE_W-1:0]     iC,
    input  logic                                        iStart,
    input  logic [LEN_W-1:0]                            iLen,
    output logic [BEAT_LANES-1:0][array_pkg::LANE_W-1:0] oData,
    output logic                                        oValid,
    input  logic                                        iReady,
    output logic                                        oLast,
    output logic                                        oBusy,
    output logic                                        oDrop
);

    import array_pkg::*;

    localparam int unsigned NBEATS = LANES / BEAT_LANES;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    drain_state_e                 state_q, state_d;
    logic [LEN_W-1:0]             cnt_q, cnt_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic [LANES-1:0][LANE_W-1:0] snap_q, snap_d;
    logic                         drop_q, drop_d;

    // State register: all sequential state, aborted to IDLE asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            snap_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            snap_q  <= snap_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic: count down, capture the lanes once, then step beats.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        snap_d  = snap_q;
        drop_d  = iStart && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    if (iLen != '0) begin
                        cnt_d   = iLen - 1'b1;
                        state_d = COUNT;
                    end else begin
                        snap_d  = iC;
                        beat_d  = '0;
                        state_d = DRAIN;
                    end
                end
            end
            COUNT: begin
                if (cnt_q == '0) begin
                    snap_d  = iC;
                    beat_d  = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DRAIN: begin
                if (iReady) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: beat mux from the registered snapshot, zero when not valid.
    always_comb begin
        oValid = (state_q == DRAIN);
        oBusy  = (state_q != IDLE);
        oLast  = oValid && (beat_q == LAST_BEAT);
        oDrop  = drop_q;
        oData  = '0;
        if (oValid) begin
            oData = snap_q[32'(beat_q) * BEAT_LANES +: BEAT_LANES];
        end
    end

endmodule

// File: tb/tb_array_drain.sv
// Scoreboard bench for array_drain: a transaction-level model predicts the
// beats and per-cycle status, a negedge monitor compares against the DUT.
module tb_array_drain;

    import array_pkg::*;

    localparam int unsigned NB = LANES / BEAT_LANES;

    typedef logic [BEAT_LANES-1:0][LANE_W-1:0] beat_t;
    typedef struct {
        beat_t data;
        bit    last;
    } exp_beat_t;
    typedef struct {
        bit valid;
        bit busy;
        bit drop;
    } exp_cyc_t;

    logic                         clk;
    logic                         rst_n;
    logic [LANES-1:0][LANE_W-1:0] iC;
    logic                         iStart;
    logic [15:0]                  iLen;
    beat_t                        oData;
    logic                         oValid;
    logic                         iReady;
    logic                         oLast;
    logic                         oBusy;
    logic                         oDrop;

    array_drain #(
        .LANES      (LANES),
        .BEAT_LANES (BEAT_LANES),
        .LEN_W      (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iC     (iC),
        .iStart (iStart),
        .iLen   (iLen),
        .oData  (oData),
        .oValid (oValid),
        .iReady (iReady),
        .oLast  (oLast),
        .oBusy  (oBusy),
        .oDrop  (oDrop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          mon_en = 1'b0;
    int unsigned ecount = 0;

    exp_beat_t beat_q[$];
    exp_cyc_t  cyc_q[$];

    // Reference model: phase 0 = idle, 1 = waiting, 2 = streaming.
    int unsigned m_phase = 0;
    int unsigned m_wait  = 0;
    int unsigned m_left  = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
        end
    endfunction

    function automatic logic [LANE_W-1:0] lane_val(int unsigned k, int unsigned i);
        return LANE_W'(k * 256 + i);
    endfunction

    // The array presents lane i = 0x0100*k + i at edge k; a capture at edge k
    // therefore yields beat b lane j = 0x0100*k + 8b + j.
    function automatic void capture(int unsigned k);
        exp_beat_t eb;
        for (int unsigned b = 0; b < NB; b++) begin
            for (int unsigned j = 0; j < BEAT_LANES; j++)
                eb.data[j] = lane_val(k, b * BEAT_LANES + j);
            eb.last = (b == NB - 1);
            beat_q.push_back(eb);
        end
        m_left  = NB;
        m_phase = 2;
    endfunction

    function automatic exp_cyc_t model_edge(int unsigned k, bit st, logic [15:0] ln, bit rd);
        exp_cyc_t e;
        e.drop = st && (m_phase != 0);
        case (m_phase)
            0: if (st) begin
                if (ln == 16'd0) capture(k);
                else begin
                    m_wait  = ln;
                    m_phase = 1;
                end
            end
            1: begin
                m_wait--;
                if (m_wait == 0) capture(k);
            end
            default: if (rd) begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
        e.busy  = (m_phase != 0);
        e.valid = (m_phase == 2);
        return e;
    endfunction

    // One clock: drive inputs for the next edge, predict it, then post the
    // prediction once the edge has happened.
    task automatic step(input bit st, input logic [15:0] ln, input bit rd);
        exp_cyc_t    e;
        int unsigned kk;
        kk     = ecount + 1;
        iStart = st;
        iLen   = ln;
        iReady = rd;
        for (int unsigned i = 0; i < LANES; i++) iC[i] = lane_val(kk, i);
        e = model_edge(kk, st, ln, rd);
        @(posedge clk);
        #2;
        ecount = kk;
        cyc_q.push_back(e);
    endtask

    task automatic idle_until(input int unsigned k);
        while (ecount + 1 < k) step(1'b0, 16'd0, 1'b1);
    endtask

    // mode 0: ready high, 1: pattern 1,0,0,1, 2: random ready.
    task automatic wait_idle(input int unsigned mode, input int unsigned bound);
        int unsigned n = 0;
        bit rd;
        while (m_phase != 0 && n < bound) begin
            case (mode)
                0:       rd = 1'b1;
                1:       rd = (n % 4 == 0) || (n % 4 == 3);
                default: rd = ($urandom_range(0, 2) != 0);
            endcase
            step(1'b0, 16'd0, rd);
            n++;
        end
        if (m_phase != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: cycle budget %0d expired", bound);
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_valid", 128'(oValid), 128'(0));
        chk("rst_data", 128'(oData), 128'(0));
        chk("rst_last", 128'(oLast), 128'(0));
        chk("rst_busy", 128'(oBusy), 128'(0));
        chk("rst_drop", 128'(oDrop), 128'(0));
        beat_q.delete();
        cyc_q.delete();
        m_phase = 0;
        m_left  = 0;
        m_wait  = 0;
        iStart  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        ecount = 0;
        mon_en = 1'b1;
    endtask

    // Monitor: per-cycle status and beat-by-beat scoreboard comparison.
    always @(negedge clk) begin : monitor
        exp_cyc_t e;
        if (mon_en) begin
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("valid", 128'(oValid), 128'(e.valid));
                chk("busy", 128'(oBusy), 128'(e.busy));
                chk("drop", 128'(oDrop), 128'(e.drop));
            end
            if (oValid === 1'b1) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %h with no beat expected", oData);
                end else begin
                    chk("beat_data", 128'(oData), 128'(beat_q[0].data));
                    chk("beat_last", 128'(oLast), 128'(beat_q[0].last));
                    if (iReady === 1'b1) void'(beat_q.pop_front());
                end
            end else begin
                chk("idle_data", 128'(oData), 128'(0));
                chk("idle_last", 128'(oLast), 128'(0));
            end
        end
    end

    initial begin
        rst_n  = 1'b1;
        iStart = 1'b0;
        iLen   = '0;
        iReady = 1'b0;
        iC     = '0;
        #3;
        do_reset();

        // Basic drain: len 3 accepted at edge 10, capture at edge 13.
        idle_until(10);
        step(1'b1, 16'd3, 1'b1);
        wait_idle(0, 40);
        repeat (2) step(1'b0, 16'd0, 1'b1);

        // Zero length: start at edge 20 after a fresh reset.
        do_reset();
        idle_until(20);
        step(1'b1, 16'd0, 1'b1);
        wait_idle(0, 40);

        // Backpressure with ready pattern 1,0,0,1.
        step(1'b1, 16'd2, 1'b0);
        wait_idle(1, 200);

        // Dropped starts: during COUNT, mid-DRAIN, on the final handshake.
        step(1'b1, 16'd2, 1'b1);
        step(1'b1, 16'd0, 1'b1);
        while (m_phase != 2) step(1'b0, 16'd0, 1'b1);
        step(1'b0, 16'd0, 1'b1);
        step(1'b1, 16'd5, 1'b1);
        while (m_left > 1) step(1'b0, 16'd0, 1'b1);
        step(1'b1, 16'd7, 1'b1);
        step(1'b1, 16'd1, 1'b1);
        wait_idle(0, 40);

        // Reset in the middle of a drain, after beat 3 has been accepted.
        step(1'b1, 16'd1, 1'b1);
        while (!(m_phase == 2 && m_left == NB - 4)) step(1'b0, 16'd0, 1'b1);
        do_reset();
        repeat (5) step(1'b0, 16'd0, 1'b1);
        step(1'b1, 16'd4, 1'b1);
        wait_idle(2, 200);

        // Randomized starts, lengths and ready.
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 5) == 0, 16'($urandom_range(0, 6)),
                 $urandom_range(0, 3) != 0);
        wait_idle(2, 200);

        // Longest length: capture exactly 65535 edges after acceptance.
        step(1'b1, 16'hFFFF, 1'b1);
        wait_idle(0, 70000);

        repeat (3) step(1'b0, 16'd0, 1'b1);
        chk("leftover_beats", 128'(beat_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
